rr_bus_arbiter: RTL and testbench



---
 rtl/rr_bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_rr_bus_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter
// Round-robin owner selection for one shared WIDTH-bit bus. A winner is picked
// in IDLE, granted for one burst (up to MAX_HOLD beats), then released. Every
// release passes through at least one IDLE cycle before the next grant.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req        per-requester request, held while beats remain
//   req_last   per-requester final-beat marker
//   req_data   packed requester data, requester i at [i*WIDTH +: WIDTH]
//   grant      registered one-hot grant (all zero in IDLE)
//   bus_valid  owner's live request while granted
//   bus_data   owner's live data while granted, zero in IDLE
//   bus_sel    registered owner index, holds its value through IDLE
//   bus_ready  shared resource accepts the current beat
//   busy       registered, high while a grant is held
module rr_bus_arbiter #(
  parameter int N        = 4,
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = 8,
  localparam int SEL_W   = (N < 2) ? 1 : $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         req_last,
  input  logic [N*WIDTH-1:0]   req_data,
  output logic [N-1:0]         grant,
  output logic                 bus_valid,
  output logic [WIDTH-1:0]     bus_data,
  output logic [SEL_W-1:0]     bus_sel,
  input  logic                 bus_ready,
  output logic                 busy
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t             r_state, w_state_next;
  logic [SEL_W-1:0]   r_owner, w_owner_next;
  logic [SEL_W-1:0]   r_last, w_last_next;
  logic [7:0]         r_beat_cnt, w_beat_cnt_next;
  logic [N-1:0]       r_grant, w_grant_next;
  logic               r_busy, w_busy_next;

  logic [WIDTH-1:0]   w_data_arr [N];
  logic [SEL_W-1:0]   w_winner;
  logic               w_found;
  logic               w_xfer;
  logic               w_hit_max;
  logic               w_release;

  // Unpack the flat data vector so the bus mux is a plain array select.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign w_data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Search starts one past the previous owner and wraps, so the requester
  // served last has the lowest priority on the next arbitration.
  always_comb begin
    w_winner = r_last;
    w_found  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!w_found && req[(int'(r_last) + k) % N]) begin
        w_winner = SEL_W'((int'(r_last) + k) % N);
        w_found  = 1'b1;
      end
    end
  end

  assign w_xfer    = (r_state == ST_GRANT) && req[r_owner] && bus_ready;
  assign w_hit_max = ({1'b0, r_beat_cnt} + 9'd1) == 9'(MAX_HOLD);
  // A withdrawn request ends the grant without a transfer; otherwise the
  // grant ends only on a beat that actually transfers.
  assign w_release = (r_state == ST_GRANT) &&
                     (!req[r_owner] || (w_xfer && (req_last[r_owner] || w_hit_max)));

  always_comb begin
    w_state_next    = r_state;
    w_owner_next    = r_owner;
    w_last_next     = r_last;
    w_beat_cnt_next = r_beat_cnt;
    w_grant_next    = r_grant;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_state_next            = ST_GRANT;
          w_owner_next            = w_winner;
          w_beat_cnt_next         = 8'd0;
          w_grant_next            = '0;
          w_grant_next[w_winner]  = 1'b1;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_state_next    = ST_IDLE;
          w_last_next     = r_owner;
          w_beat_cnt_next = 8'd0;
          w_grant_next    = '0;
        end else if (w_xfer) begin
          w_beat_cnt_next = r_beat_cnt + 8'd1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_grant_next = '0;
      end
    endcase
    w_busy_next = (w_state_next == ST_GRANT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_owner    <= '0;
      r_last     <= SEL_W'(N - 1);
      r_beat_cnt <= 8'd0;
      r_grant    <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_owner    <= w_owner_next;
      r_last     <= w_last_next;
      r_beat_cnt <= w_beat_cnt_next;
      r_grant    <= w_grant_next;
      r_busy     <= w_busy_next;
    end
  end

  assign grant     = r_grant;
  assign busy      = r_busy;
  assign bus_sel   = r_owner;
  assign bus_valid = (r_state == ST_GRANT) && req[r_owner];
  assign bus_data  = (r_state == ST_GRANT) ? w_data_arr[r_owner] : '0;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Bench for rr_bus_arbiter: directed scenarios with literal expectations plus
// a cycle-by-cycle comparison against a behavioural model of the arbiter.
module tb_rr_bus_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int MH = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req, req_last;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   grant;
  logic           bus_valid;
  logic [W-1:0]   bus_data;
  logic [1:0]     bus_sel;
  logic           bus_ready;
  logic           busy;

  always #5 clk = ~clk;

  rr_bus_arbiter #(.N(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_last(req_last),
    .req_data(req_data), .grant(grant), .bus_valid(bus_valid),
    .bus_data(bus_data), .bus_sel(bus_sel), .bus_ready(bus_ready),
    .busy(busy)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: whether a grant is held, who owns it, who was served
  // last and how many beats this grant has moved.
  bit m_in_grant = 1'b0;
  int m_owner    = 0;
  int m_last     = N - 1;
  int m_cnt      = 0;

  // Observation logs filled from the DUT outputs.
  int           grant_log [$];
  int           gap_log   [$];
  int           burst_log [$];
  int           cur_burst = 0;
  int           zero_run  = 0;
  logic [N-1:0] prev_grant = '0;

  always @(negedge clk) begin : cmp_proc
    logic [N-1:0] e_grant;
    logic         e_valid;
    logic [W-1:0] e_data;
    bit           found;
    if (chk_en) begin
      e_grant = '0;
      if (m_in_grant) e_grant[m_owner] = 1'b1;
      e_valid = m_in_grant && req[m_owner];
      e_data  = m_in_grant ? req_data[m_owner*W +: W] : '0;
      check("grant", grant, e_grant);
      check("busy", busy, m_in_grant);
      check("bus_valid", bus_valid, e_valid);
      check("bus_data", bus_data, e_data);
      check("bus_sel", bus_sel, m_owner);

      if (grant != 0 && prev_grant == 0) begin
        grant_log.push_back(grant);
        gap_log.push_back(zero_run);
        zero_run  = 0;
        cur_burst = 0;
      end
      if (grant == 0 && prev_grant != 0) burst_log.push_back(cur_burst);
      if (grant == 0) zero_run++;
      if (rst_n && bus_valid && bus_ready) begin
        cur_burst++;
        $display("xfer owner=%0d data=%h", bus_sel, bus_data);
      end
      prev_grant = grant;

      if (!rst_n) begin
        m_in_grant = 1'b0; m_owner = 0; m_last = N - 1; m_cnt = 0;
      end else if (!m_in_grant) begin
        if (req != 0) begin
          found = 1'b0;
          for (int k = 1; k <= N; k++) begin
            if (!found && req[(m_last + k) % N]) begin
              m_owner = (m_last + k) % N;
              found   = 1'b1;
            end
          end
          m_in_grant = 1'b1;
          m_cnt      = 0;
        end
      end else if (!req[m_owner]) begin
        m_last = m_owner; m_in_grant = 1'b0; m_cnt = 0;
      end else if (bus_ready) begin
        if (req_last[m_owner] || m_cnt + 1 == MH) begin
          m_last = m_owner; m_in_grant = 1'b0; m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    grant_log.delete();
    gap_log.delete();
    burst_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req = '0; req_last = '0; req_data = '0; bus_ready = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    step();
    #1;
    check("rst_grant", grant, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", bus_valid, 1'b0);
    check("rst_data", bus_data, 16'h0000);
    check("rst_sel", bus_sel, 2'd0);
    rst_n = 1'b1;

    // Single requester, two-beat burst.
    clear_logs();
    req = 4'b0001; req_data[0 +: W] = 16'h1234;
    #1 check("s1_latency", grant, 4'b0000);
    step(); #1;
    check("s1_grant", grant, 4'b0001);
    check("s1_data", bus_data, 16'h1234);
    check("s1_sel", bus_sel, 2'd0);
    step(); req_last = 4'b0001;
    step(); req = '0; req_last = '0;
    #1 check("s1_released", grant, 4'b0000);
    step(); #1 check("s1_idle", grant, 4'b0000);
    step();
    check("s1_beats", burst_log[0], 2);

    // All four requesting, single-beat bursts, from a fresh pointer.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    clear_logs();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 16'hA000 + 16'(i);
    req = 4'b1111; req_last = 4'b1111;
    repeat (11) step();
    req = '0; req_last = '0;
    repeat (3) step();
    check("s2_g0", grant_log[0], 4'b0001);
    check("s2_g1", grant_log[1], 4'b0010);
    check("s2_g2", grant_log[2], 4'b0100);
    check("s2_g3", grant_log[3], 4'b1000);
    check("s2_g4", grant_log[4], 4'b0001);
    check("s2_gap", gap_log[2], 1);

    // Requester 2 alone with no last marker: forced release after MAX_HOLD.
    clear_logs();
    req = 4'b0100; req_data[2*W +: W] = 16'hC0DE;
    repeat (14) step();
    req = '0;
    repeat (3) step();
    check("s3_max_beats", burst_log[0], 8);
    check("s3_regrant", grant_log[1], 4'b0100);
    check("s3_gap", gap_log[1], 1);

    // Requester 1 stalled for five cycles; the stall must not consume beats.
    clear_logs();
    req = 4'b0010; req_data[1*W +: W] = 16'h5A5A; bus_ready = 1'b0;
    step(); #1 check("s4_grant", grant, 4'b0010);
    for (int i = 0; i < 5; i++) begin
      step(); #1;
      check("s4_stall_grant", grant, 4'b0010);
      check("s4_stall_valid", bus_valid, 1'b1);
    end
    bus_ready = 1'b1;
    repeat (8) step();
    req = '0;
    #1 check("s4_released", grant, 4'b0000);
    repeat (2) step();
    check("s4_beats", burst_log[0], 8);

    // Requester 3 owns, reset after its first beat; requester 0 wins after.
    clear_logs();
    req = 4'b1001; req_data[3*W +: W] = 16'h3333; req_data[0 +: W] = 16'h0F0F;
    step(); #1;
    check("s5_grant", grant, 4'b1000);
    check("s5_sel", bus_sel, 2'd3);
    step();
    rst_n = 1'b0;
    step(); #1;
    check("s5_rst_grant", grant, 4'b0000);
    check("s5_rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    step(); #1 check("s5_after_rst", grant, 4'b0001);
    req_last = 4'b0001;
    step(); req = '0; req_last = '0;
    repeat (2) step();

    // Requester 0 withdraws mid-burst while requester 1 waits.
    clear_logs();
    req = 4'b0001; req_data[0 +: W] = 16'h0BAD;
    step(); #1 check("s6_grant0", grant, 4'b0001);
    req = 4'b0011;
    step();
    req = 4'b0010;
    #1 check("s6_withdraw_valid", bus_valid, 1'b0);
    step(); #1 check("s6_release", grant, 4'b0000);
    step(); #1 check("s6_grant1", grant, 4'b0010);
    req_last = 4'b0010;
    step(); req = '0; req_last = '0;
    repeat (3) step();
    check("s6_owner0_beats", burst_log[0], 1);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
